ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit of the multi-cycle NPC core; sits directly upstream of the decode stage.
- Owns the architectural PC and issues one request at a time to the instruction memory port.
- Presents the fetched 32-bit instruction and its PC to decode over a valid/ready handshake.
- Waits for the execute/writeback side to return the next PC, then fetches again.
- Stops permanently when the core signals halt (EBREAK).

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset; first fetch address.
- XLEN, 32, width of the PC, addresses and instruction data.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request is valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  fetch address; equals the current PC.
- imem_resp_valid  in  1  response data is valid.
- imem_resp_data  in  XLEN  instruction word.
- imem_resp_err  in  1  bus error on this response.
- inst_valid  out  1  instruction is available to decode.
- inst_ready  in  1  decode consumes the instruction.
- inst  out  XLEN  instruction word delivered to decode.
- inst_pc  out  XLEN  PC of the delivered instruction.
- inst_fault  out  1  fetch fault (bus error or misaligned PC); `inst` is NOP when set.
- npc_valid  in  1  next PC is valid (one-cycle pulse from writeback).
- npc  in  XLEN  next PC.
- halt  in  1  core halt request.
- halted  out  1  fetch has stopped permanently.
- fetch_cnt  out  32  number of instructions accepted by decode; wraps at 2^32.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to REQ and pc = RESET_PC.
  - Output reset values: inst = 32'h0000_0013, inst_fault = 0, fetch_cnt = 0, halted = 0, inst_valid = 0, imem_req_valid = 0.
  - After rst_n deasserts, imem_req_valid rises on the first clock edge.
  - Reset mid-transaction abandons the transaction; a late imem_resp_valid arriving in REQ is ignored.
- FSM states: REQ, RESP, VALID, WAIT_NPC, HALTED.
- REQ:
  - Drive imem_req_valid = 1 and imem_req_addr = pc.
  - If imem_req_ready = 1, go to RESP.
  - The request stays asserted, with a stable address, until accepted.
- RESP:
  - imem_req_valid = 0.
  - On imem_resp_valid: inst = resp_err ? NOP : resp_data; inst_fault = resp_err; inst_pc = pc; go to VALID.
  - Fastest path: request accepted in cycle 0, response in cycle 1, inst_valid high in cycle 2.
- VALID:
  - inst_valid = 1; inst, inst_pc and inst_fault stay stable until accepted.
  - On inst_ready: fetch_cnt += 1 and go to WAIT_NPC.
  - Backpressure of any length is legal.
- WAIT_NPC:
  - If halt = 1, go to HALTED; halt has priority over a simultaneous npc_valid.
  - Else, if npc_valid = 1, load pc = npc.
    - If npc[1:0] != 0: skip memory; set inst = NOP, inst_fault = 1, inst_pc = npc; go to VALID.
    - Otherwise go to REQ.
- HALTED:
  - Terminal state; only reset leaves it.
  - halted = 1; no further requests or deliveries.
- Ignored inputs:
  - npc_valid is ignored in every state except WAIT_NPC.
  - halt is ignored outside WAIT_NPC.
- Outputs are registered; no combinational path from any input to inst_valid or imem_req_valid.

Decomposition:
- Package npc_pkg:
  - ifu state enum: REQ, RESP, VALID, WAIT_NPC, HALTED.
  - NOP_INST = 32'h0000_0013.
  - RESET_PC default.
- No sub-module; a single FSM plus datapath registers.

Test Plan:
- Reset then zero-wait memory returning 32'h0010_0093 → inst_valid at cycle 2, inst = 32'h0010_0093, inst_pc = 32'h8000_0000, fetch_cnt = 1 after the handshake.
- imem_req_ready held low for 5 cycles → imem_req_valid and addr stay stable throughout; exactly one request is accepted.
- inst_ready held low for 4 cycles → inst, inst_pc, inst_valid stable; fetch_cnt increments once.
- npc = 32'h8000_0102 → no memory request; inst_fault = 1, inst = 32'h0000_0013, inst_pc = 32'h8000_0102.
- imem_resp_err = 1 → inst_fault = 1, inst = NOP; the next fetch is normal after npc_valid.
- halt and npc_valid asserted together in WAIT_NPC → halted = 1, no further imem_req_valid; rst_n pulse mid-RESP restarts at RESET_PC with fetch_cnt = 0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC core front end.
// Holds the fetch FSM state encoding, the canonical NOP and the default reset PC.
package npc_pkg;

    typedef enum logic [2:0] {
        ST_REQ      = 3'd0,
        ST_RESP     = 3'd1,
        ST_VALID    = 3'd2,
        ST_WAIT_NPC = 3'd3,
        ST_HALTED   = 3'd4
    } ifu_state_e;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Instructions are 4-byte aligned; any set low bit is a fetch fault.
    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return (pc_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and hands it to decode.
// Every output comes straight from a register, so no input reaches a valid combinationally.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_fault,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    input  logic            halt,
    output logic            halted,
    output logic [31:0]     fetch_cnt
);

    localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP_INST);

    ifu_state_e      state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] inst_r;
    logic [XLEN-1:0] inst_pc_r;
    logic            inst_fault_r;
    logic            inst_valid_r;
    logic            req_valid_r;
    logic            halted_r;
    logic [31:0]     fetch_cnt_r;

    // Fetch FSM together with the PC, delivery and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_REQ;
            pc_r         <= RESET_PC;
            inst_r       <= NOP_W;
            inst_pc_r    <= RESET_PC;
            inst_fault_r <= 1'b0;
            inst_valid_r <= 1'b0;
            req_valid_r  <= 1'b0;
            halted_r     <= 1'b0;
            fetch_cnt_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_REQ: begin
                    // Only the first REQ after reset arrives with the request low.
                    if (!req_valid_r) begin
                        req_valid_r <= 1'b1;
                    end else if (imem_req_ready) begin
                        req_valid_r <= 1'b0;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (imem_resp_valid) begin
                        inst_r       <= imem_resp_err ? NOP_W : imem_resp_data;
                        inst_fault_r <= imem_resp_err;
                        inst_pc_r    <= pc_r;
                        inst_valid_r <= 1'b1;
                        state_r      <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (inst_ready) begin
                        inst_valid_r <= 1'b0;
                        fetch_cnt_r  <= fetch_cnt_r + 32'd1;
                        state_r      <= ST_WAIT_NPC;
                    end
                end
                ST_WAIT_NPC: begin
                    if (halt) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_HALTED;
                    end else if (npc_valid) begin
                        pc_r <= npc;
                        if (pc_misaligned(npc[1:0])) begin
                            inst_r       <= NOP_W;
                            inst_fault_r <= 1'b1;
                            inst_pc_r    <= npc;
                            inst_valid_r <= 1'b1;
                            state_r      <= ST_VALID;
                        end else begin
                            req_valid_r <= 1'b1;
                            state_r     <= ST_REQ;
                        end
                    end
                end
                ST_HALTED: begin
                    halted_r     <= 1'b1;
                    req_valid_r  <= 1'b0;
                    inst_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_REQ;
                    req_valid_r  <= 1'b0;
                    inst_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_req_addr  = pc_r;
    assign inst_valid     = inst_valid_r;
    assign inst           = inst_r;
    assign inst_pc        = inst_pc_r;
    assign inst_fault     = inst_fault_r;
    assign halted         = halted_r;
    assign fetch_cnt      = fetch_cnt_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch: the stimulus side predicts each delivery,
// an independent monitor pops and compares whenever decode accepts an instruction.
module tb_ifu_fetch;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h8000_0000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        npc_valid;
    logic [31:0] npc;
    logic        halt;
    logic        halted;
    logic [31:0] fetch_cnt;

    int          n_assert;
    int          n_fail;
    int          exp_cnt;
    int          req_seen;
    int          req_exp;
    logic [31:0] model_pc;
    exp_t        exp_q[$];

    ifu_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_fault      (inst_fault),
        .npc_valid       (npc_valid),
        .npc             (npc),
        .halt            (halt),
        .halted          (halted),
        .fetch_cnt       (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change #1 after the rising edge; outputs read there are post-edge values.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs and outputs are both settled at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cnt = 0;
        end else begin
            if (imem_req_valid && imem_req_ready) req_seen++;
            if (inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_delivery", inst_pc, 32'hxxxx_xxxx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_inst", inst, e.inst);
                    chk("sb_pc", inst_pc, e.pc);
                    chk("sb_fault", {31'd0, inst_fault}, {31'd0, e.fault});
                end
                chk("sb_fetch_cnt", fetch_cnt, exp_cnt);
                exp_cnt++;
            end
        end
    end

    // Memory side: accept the pending request after rdy_wait cycles, answer after resp_wait.
    task automatic serve_fetch(input int rdy_wait, input int resp_wait,
                               input logic err, input logic [31:0] data);
        int   t;
        exp_t e;
        t = 0;
        while (!imem_req_valid && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) chk("req_timeout", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_req_addr, model_pc);
        for (int i = 0; i < rdy_wait; i++) begin
            tick();
            chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("req_hold_addr", imem_req_addr, model_pc);
        end
        imem_req_ready = 1'b1;
        req_exp++;
        tick();
        imem_req_ready = 1'b0;
        chk("req_drop", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 0; i < resp_wait; i++) begin
            // Writeback and halt are meaningless while a fetch is in flight.
            npc_valid = (i == 0);
            halt      = (i == 0);
            npc       = $urandom;
            tick();
        end
        npc_valid       = 1'b0;
        halt            = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        imem_resp_err   = err;
        e.inst  = err ? NOP : data;
        e.pc    = model_pc;
        e.fault = err;
        exp_q.push_back(e);
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        imem_resp_data  = $urandom;
        chk("resp_to_valid", {31'd0, inst_valid}, 32'd1);
    endtask

    // Decode side: stall for a while, checking the offer stays put, then accept it.
    task automatic decode(input int stall);
        int          t;
        logic [31:0] i0;
        logic [31:0] p0;
        logic        f0;
        t = 0;
        while (!inst_valid && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) chk("inst_timeout", {31'd0, inst_valid}, 32'd1);
        i0 = inst;
        p0 = inst_pc;
        f0 = inst_fault;
        for (int i = 0; i < stall; i++) begin
            npc_valid = (i == 0);
            halt      = (i == 0);
            npc       = $urandom;
            tick();
            npc_valid = 1'b0;
            halt      = 1'b0;
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_inst", inst, i0);
            chk("stall_pc", inst_pc, p0);
            chk("stall_fault", {31'd0, inst_fault}, {31'd0, f0});
            chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        chk("valid_drop", {31'd0, inst_valid}, 32'd0);
    endtask

    // Writeback side: return the next PC (optionally with halt in the same cycle).
    task automatic give_npc(input logic [31:0] n, input logic h);
        exp_t e;
        npc_valid = 1'b1;
        npc       = n;
        halt      = h;
        if (!h) begin
            model_pc = n;
            if (n[1:0] != 2'b00) begin
                e.inst  = NOP;
                e.pc    = n;
                e.fault = 1'b1;
                exp_q.push_back(e);
            end
        end
        tick();
        npc_valid = 1'b0;
        halt      = 1'b0;
        npc       = $urandom;
        if (h) begin
            chk("halted_set", {31'd0, halted}, 32'd1);
        end else if (n[1:0] != 2'b00) begin
            chk("misaligned_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("misaligned_valid", {31'd0, inst_valid}, 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] n;
        n_assert = 0;
        n_fail   = 0;
        req_seen = 0;
        req_exp  = 0;
        model_pc = RPC;
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = 32'd0;
        imem_resp_err = 1'b0;
        inst_ready = 1'b0;
        npc_valid = 1'b0;
        npc = 32'd0;
        halt = 1'b0;
        repeat (3) tick();
        chk("rst_inst", inst, NOP);
        chk("rst_fault", {31'd0, inst_fault}, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("first_req_edge", {31'd0, imem_req_valid}, 32'd1);

        // Zero-wait fetch, then long request and decode backpressure.
        serve_fetch(0, 0, 1'b0, 32'h0010_0093);
        decode(0);
        chk("cnt_after_first", fetch_cnt, 32'd1);
        give_npc(32'h8000_0004, 1'b0);
        serve_fetch(5, 2, 1'b0, 32'h00a0_0513);
        decode(4);
        chk("cnt_after_stall", fetch_cnt, 32'd2);

        // Misaligned next PC, then a bus error, then a clean fetch.
        give_npc(32'h8000_0102, 1'b0);
        decode(1);
        give_npc(32'h8000_0200, 1'b0);
        serve_fetch(1, 1, 1'b1, 32'hdead_beef);
        decode(0);
        give_npc(32'h8000_0204, 1'b0);
        serve_fetch(0, 3, 1'b0, 32'h0000_0073);
        decode(2);

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            r = $urandom;
            n = {r[31:2], 2'b00};
            if ($urandom_range(0, 4) == 0) n[1:0] = 2'($urandom_range(1, 3));
            repeat ($urandom_range(0, 2)) tick();
            give_npc(n, 1'b0);
            if (n[1:0] == 2'b00) begin
                serve_fetch($urandom_range(0, 3), $urandom_range(0, 3),
                            ($urandom_range(0, 7) == 0), $urandom);
            end
            decode($urandom_range(0, 3));
        end
        chk("cnt_after_random", fetch_cnt, exp_cnt);

        // Reset while waiting for a response, then a stale response in REQ.
        give_npc(32'h8000_1000, 1'b0);
        tick();
        imem_req_ready = 1'b1;
        req_exp++;
        tick();
        imem_req_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        model_pc = RPC;
        tick();
        chk("midrst_cnt", fetch_cnt, 32'd0);
        chk("midrst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("midrst_req_addr", imem_req_addr, RPC);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        tick();
        imem_resp_valid = 1'b0;
        chk("stale_resp_ignored", {31'd0, inst_valid}, 32'd0);
        serve_fetch(0, 0, 1'b0, 32'h0041_0113);
        decode(0);
        chk("cnt_after_midrst", fetch_cnt, 32'd1);

        // Halt wins over a simultaneous next PC and is terminal.
        give_npc(32'h8000_0010, 1'b1);
        for (int i = 0; i < 10; i++) begin
            imem_req_ready = 1'b1;
            npc_valid = 1'b1;
            npc = 32'h8000_0020;
            tick();
            chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("halt_no_inst", {31'd0, inst_valid}, 32'd0);
            chk("halt_stays", {31'd0, halted}, 32'd1);
        end
        imem_req_ready = 1'b0;
        npc_valid = 1'b0;
        tick();

        chk("req_handshakes", req_seen, req_exp);
        chk("sb_drained", exp_q.size(), 32'd0);
        chk("final_cnt", fetch_cnt, exp_cnt);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
